// File: rtl/mvm_stream_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : mvm_stream_driver_if
// Brief    : Input/output handshake bundle between the stream driver
//            (master) and the matrix-vector multiplier (slave).
// Revision : 1.0  initial release
// ============================================================================
interface mvm_stream_driver_if #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 19
);
  // Operand stream towards the multiplier
  logic              mvm_in_valid;
  logic              mvm_in_ready;
  logic              mvm_new_matrix;
  logic [DATA_W-1:0] mvm_in_data;

  // Result stream back from the multiplier
  logic              mvm_out_valid;
  logic              mvm_out_ready;
  logic [OUT_W-1:0]  mvm_out_data;

  modport master (
    output mvm_in_valid,
    output mvm_new_matrix,
    output mvm_in_data,
    output mvm_out_ready,
    input  mvm_in_ready,
    input  mvm_out_valid,
    input  mvm_out_data
  );

  modport slave (
    input  mvm_in_valid,
    input  mvm_new_matrix,
    input  mvm_in_data,
    input  mvm_out_ready,
    output mvm_in_ready,
    output mvm_out_valid,
    output mvm_out_data
  );
endinterface
`default_nettype wire

// File: rtl/mvm_stream_driver.sv
`default_nettype none
// ============================================================================
// Module   : mvm_stream_driver
// Brief    : Holds a host-written 8x8 weight matrix W and 8-entry vector X,
//            streams them into the matrix-vector multiplier on start and
//            collects the 8 results into a host-readable buffer.
// Options  : MVM_STALL_INJECT_EN - gate in_valid/out_ready with a
//            free-running toggle to create handshake gaps.
// Revision : 1.0  initial release
// ============================================================================
module mvm_stream_driver #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 19
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              host_wr_en,
  input  wire logic              host_wr_sel,
  input  wire logic [5:0]        host_wr_addr,
  input  wire logic [DATA_W-1:0] host_wr_data,
  input  wire logic              start,
  input  wire logic              send_w,
  input  wire logic [2:0]        res_rd_addr,
  output logic      [OUT_W-1:0]  res_rd_data,
  output logic                   busy,
  output logic                   done,
  mvm_stream_driver_if.master    mvm
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEND_W = 3'd1,
    ST_SEND_X = 3'd2,
    ST_RECV   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [5:0]        beat_cnt_q, beat_cnt_d;
  logic [2:0]        res_cnt_q, res_cnt_d;
  logic [OUT_W-1:0]  res_rd_q;

  logic [DATA_W-1:0] w_mem_q [64];
  logic [DATA_W-1:0] x_mem_q [8];
  logic [OUT_W-1:0]  r_mem_q [8];

  logic              hs_open;
  logic              in_valid;
  logic              in_new_matrix;
  logic [DATA_W-1:0] in_data;
  logic              out_ready;
  logic              capture;
  logic              busy_d;
  logic              done_d;

`ifdef MVM_STALL_INJECT_EN
  logic gate_q;

  // Free-running toggle: the handshake is only open on every other cycle
  always_ff @(posedge clk) begin
    if (rst) gate_q <= 1'b0;
    else     gate_q <= ~gate_q;
  end

  assign hs_open = gate_q;
`else
  assign hs_open = 1'b1;
`endif

  // State and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= 6'd0;
      res_cnt_q  <= 3'd0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      res_cnt_q  <= res_cnt_d;
    end
  end

  // Next-state, counter and handshake output decode
  always_comb begin
    state_d       = state_q;
    beat_cnt_d    = beat_cnt_q;
    res_cnt_d     = res_cnt_q;
    in_valid      = 1'b0;
    in_new_matrix = 1'b0;
    in_data       = '0;
    out_ready     = 1'b0;
    capture       = 1'b0;
    busy_d        = 1'b1;
    done_d        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy_d     = 1'b0;
        beat_cnt_d = 6'd0;
        res_cnt_d  = 3'd0;
        if (start) state_d = send_w ? ST_SEND_W : ST_SEND_X;
      end
      ST_SEND_W: begin
        in_valid      = hs_open;
        in_data       = w_mem_q[beat_cnt_q];
        // Flag stays up through stalls so it is stable until beat 0 is taken
        in_new_matrix = (beat_cnt_q == 6'd0);
        if (in_valid && mvm.mvm_in_ready) begin
          // Counter wraps 63 -> 0, which is exactly the first X index
          beat_cnt_d = beat_cnt_q + 6'd1;
          if (beat_cnt_q == 6'd63) state_d = ST_SEND_X;
        end
      end
      ST_SEND_X: begin
        in_valid = hs_open;
        in_data  = x_mem_q[beat_cnt_q[2:0]];
        if (in_valid && mvm.mvm_in_ready) begin
          beat_cnt_d = beat_cnt_q + 6'd1;
          if (beat_cnt_q[2:0] == 3'd7) begin
            beat_cnt_d = 6'd0;
            state_d    = ST_RECV;
          end
        end
      end
      ST_RECV: begin
        out_ready = hs_open;
        if (out_ready && mvm.mvm_out_valid) begin
          capture   = 1'b1;
          res_cnt_d = res_cnt_q + 3'd1;
          if (res_cnt_q == 3'd7) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Host writes to W/X are honoured only while idle; contents are not reset
  always_ff @(posedge clk) begin
    if (!rst && (state_q == ST_IDLE) && host_wr_en) begin
      if (host_wr_sel) x_mem_q[host_wr_addr[2:0]] <= host_wr_data;
      else             w_mem_q[host_wr_addr]      <= host_wr_data;
    end
  end

  // Result capture into the host-visible buffer
  always_ff @(posedge clk) begin
    if (capture) r_mem_q[res_cnt_q] <= mvm.mvm_out_data;
  end

  // Registered result read; a same-cycle capture is seen on the next read
  always_ff @(posedge clk) begin
    if (rst) res_rd_q <= '0;
    else     res_rd_q <= r_mem_q[res_rd_addr];
  end

  assign res_rd_data        = res_rd_q;
  assign busy               = busy_d;
  assign done               = done_d;
  assign mvm.mvm_in_valid   = in_valid;
  assign mvm.mvm_new_matrix = in_new_matrix;
  assign mvm.mvm_in_data    = in_data;
  assign mvm.mvm_out_ready  = out_ready;

endmodule
`default_nettype wire

// File: tb/tb_mvm_stream_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_mvm_stream_driver
// Brief    : Self-checking bench for mvm_stream_driver: plays the multiplier
//            side of both handshakes and checks the beat stream, result
//            buffer, status outputs and reset behaviour against a model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mvm_stream_driver;
  localparam int DATA_W = 8;
  localparam int OUT_W  = 19;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              host_wr_en = 1'b0;
  logic              host_wr_sel = 1'b0;
  logic [5:0]        host_wr_addr = '0;
  logic [DATA_W-1:0] host_wr_data = '0;
  logic              start = 1'b0;
  logic              send_w = 1'b0;
  logic [2:0]        res_rd_addr = '0;
  logic [OUT_W-1:0]  res_rd_data;
  logic              busy;
  logic              done;

  mvm_stream_driver_if #(.DATA_W(DATA_W), .OUT_W(OUT_W)) bus ();

  mvm_stream_driver #(.DATA_W(DATA_W), .OUT_W(OUT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .host_wr_en   (host_wr_en),
    .host_wr_sel  (host_wr_sel),
    .host_wr_addr (host_wr_addr),
    .host_wr_data (host_wr_data),
    .start        (start),
    .send_w       (send_w),
    .res_rd_addr  (res_rd_addr),
    .res_rd_data  (res_rd_data),
    .busy         (busy),
    .done         (done),
    .mvm          (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: what the host last wrote and what the buffer holds
  logic [DATA_W-1:0] wm [64];
  logic [DATA_W-1:0] xm [8];
  logic [OUT_W-1:0]  rm [8];
  logic [OUT_W-1:0]  res_q [8];

  // Observations of the most recent transfer
  logic [DATA_W-1:0] got_d [$];
  logic              got_nm [$];
  int                stab_err, done_cnt, busy_cyc, consec_valid;
  bit                timed_out;
  logic              first_valid, first_busy;

  // Beat i of a transfer: W in row-major order (if sent), then X
  function automatic logic [DATA_W-1:0] exp_beat(input bit sw, input int i);
    if (sw && i < 64) return wm[i];
    return xm[(sw ? i - 64 : i) & 7];
  endfunction

  task automatic load_mem();
    for (int i = 0; i < 72; i++) begin
      @(posedge clk); #1;
      host_wr_en   = 1'b1;
      host_wr_sel  = (i >= 64);
      host_wr_addr = (i >= 64) ? 6'(i - 64) : 6'(i);
      host_wr_data = (i >= 64) ? xm[i - 64] : wm[i];
    end
    @(posedge clk); #1;
    host_wr_en = 1'b0;
  endtask

  // rmode: 0 ready high, 1 random ready, 2 ready low 3 cycles at beats 5 and 70
  task automatic run_transfer(input bit sw, input int rmode, input bit junk, input bit gaps);
    bit                pend, ov_pend, saw_done;
    logic [DATA_W-1:0] pend_d;
    logic              pend_nm, prev_valid;
    int                res_idx, s5, s70, n_beats;
    got_d.delete(); got_nm.delete();
    stab_err = 0; done_cnt = 0; busy_cyc = 0; consec_valid = 0; timed_out = 1'b1;
    pend = 0; ov_pend = 0; saw_done = 0; prev_valid = 0; pend_d = '0; pend_nm = 0;
    res_idx = 0; s5 = 0; s70 = 0; n_beats = 0;
    @(posedge clk); #1;
    start = 1'b1; send_w = sw;
    @(posedge clk); #1;
    start = 1'b0; send_w = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      case (rmode)
        0: bus.mvm_in_ready = 1'b1;
        1: bus.mvm_in_ready = 1'($urandom_range(0, 1));
        default: begin
          if (n_beats == 5 && s5 < 3) begin bus.mvm_in_ready = 1'b0; s5++; end
          else if (n_beats == 70 && s70 < 3) begin bus.mvm_in_ready = 1'b0; s70++; end
          else bus.mvm_in_ready = 1'b1;
        end
      endcase
      if (!ov_pend) begin
        bus.mvm_out_valid = (res_idx < 8) && (!gaps || $urandom_range(0, 2) == 0);
        bus.mvm_out_data  = bus.mvm_out_valid ? res_q[res_idx] : OUT_W'($urandom);
      end
      if (junk) begin
        host_wr_en   = 1'($urandom_range(0, 1));
        host_wr_sel  = 1'($urandom_range(0, 1));
        host_wr_addr = 6'($urandom);
        host_wr_data = DATA_W'($urandom);
        start        = 1'($urandom_range(0, 1));
        send_w       = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      if (cyc == 0) begin first_valid = bus.mvm_in_valid; first_busy = busy; end
      if (busy) busy_cyc++;
      if (bus.mvm_in_valid) begin
        if (pend && (bus.mvm_in_data !== pend_d || bus.mvm_new_matrix !== pend_nm)) stab_err++;
        if (bus.mvm_in_ready) begin
          got_d.push_back(bus.mvm_in_data);
          got_nm.push_back(bus.mvm_new_matrix);
          n_beats++;
          pend = 0;
        end else begin
          if (!pend) begin pend_d = bus.mvm_in_data; pend_nm = bus.mvm_new_matrix; end
          pend = 1;
        end
      end
`ifndef MVM_STALL_INJECT_EN
      else if (pend) stab_err++;
`endif
      if (prev_valid && bus.mvm_in_valid) consec_valid++;
      prev_valid = bus.mvm_in_valid;
      if (bus.mvm_out_valid) ov_pend = !bus.mvm_out_ready;
      if (bus.mvm_out_valid && bus.mvm_out_ready) res_idx++;
      if (done) begin done_cnt++; saw_done = 1; end
      @(posedge clk); #1;
      if (saw_done) begin timed_out = 1'b0; break; end
    end
    host_wr_en = 1'b0; start = 1'b0; send_w = 1'b0;
    bus.mvm_out_valid = 1'b0; bus.mvm_in_ready = 1'b0;
    if (!timed_out) for (int k = 0; k < 8; k++) rm[k] = res_q[k];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++; if (bus.mvm_in_valid !== 1'b0) begin n_err++; $display("FAIL reset_in_valid: got %b expected 0", bus.mvm_in_valid); end
    n_vec++; if (bus.mvm_new_matrix !== 1'b0) begin n_err++; $display("FAIL reset_new_matrix: got %b expected 0", bus.mvm_new_matrix); end
    n_vec++; if (bus.mvm_out_ready !== 1'b0) begin n_err++; $display("FAIL reset_out_ready: got %b expected 0", bus.mvm_out_ready); end
    n_vec++; if (bus.mvm_in_data !== '0) begin n_err++; $display("FAIL reset_in_data: got %h expected 0", bus.mvm_in_data); end
    n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL reset_busy_done: got %b%b expected 00", busy, done); end
    n_vec++; if (res_rd_data !== '0) begin n_err++; $display("FAIL reset_res_rd_data: got %h expected 0", res_rd_data); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic_stream();
    for (int i = 0; i < 64; i++) wm[i] = DATA_W'(i);
    for (int j = 0; j < 8; j++) xm[j] = DATA_W'(1);
    for (int k = 0; k < 8; k++) res_q[k] = OUT_W'(100 + k);
    load_mem();
    run_transfer(1'b1, 0, 1'b0, 1'b0);
    n_vec++; if (timed_out) begin n_err++; $display("FAIL basic_timeout: got no done expected done"); end
    n_vec++; if (got_d.size() != 72) begin n_err++; $display("FAIL basic_beat_count: got %0d expected 72", got_d.size()); end
    for (int i = 0; i < got_d.size() && i < 72; i++) begin
      n_vec++;
      if (got_d[i] !== exp_beat(1'b1, i) || got_nm[i] !== (i == 0)) begin
        n_err++; $display("FAIL basic_beat[%0d]: got %h/%b expected %h/%b", i, got_d[i], got_nm[i], exp_beat(1'b1, i), (i == 0));
      end
    end
    n_vec++; if (first_busy !== 1'b1) begin n_err++; $display("FAIL basic_first_busy: got %b expected 1", first_busy); end
`ifndef MVM_STALL_INJECT_EN
    n_vec++; if (first_valid !== 1'b1) begin n_err++; $display("FAIL basic_first_valid: got %b expected 1", first_valid); end
    n_vec++; if (busy_cyc != 81) begin n_err++; $display("FAIL basic_busy_cycles: got %0d expected 81", busy_cyc); end
`else
    n_vec++; if (consec_valid != 0) begin n_err++; $display("FAIL stall_consec_valid: got %0d expected 0", consec_valid); end
`endif
    n_vec++; if (done_cnt != 1) begin n_err++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt); end
    @(negedge clk);
    n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL basic_after_done: got busy %b done %b expected 0 0", busy, done); end
    @(posedge clk); #1;
    for (int a = 0; a < 8; a++) begin
      res_rd_addr = 3'(a);
      @(posedge clk); @(negedge clk);
      n_vec++; if (res_rd_data !== rm[a]) begin n_err++; $display("FAIL basic_readback[%0d]: got %0d expected %0d", a, res_rd_data, rm[a]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 64; i++) wm[i] = DATA_W'($urandom);
    for (int j = 0; j < 8; j++) xm[j] = DATA_W'($urandom);
    for (int k = 0; k < 8; k++) res_q[k] = OUT_W'($urandom);
    load_mem();
    run_transfer(1'b1, 2, 1'b0, 1'b1);
    n_vec++; if (timed_out) begin n_err++; $display("FAIL bp_timeout: got no done expected done"); end
    n_vec++; if (stab_err != 0) begin n_err++; $display("FAIL bp_stability: got %0d violations expected 0", stab_err); end
    n_vec++; if (got_d.size() != 72) begin n_err++; $display("FAIL bp_beat_count: got %0d expected 72", got_d.size()); end
    for (int i = 0; i < got_d.size() && i < 72; i++) begin
      n_vec++;
      if (got_d[i] !== exp_beat(1'b1, i) || got_nm[i] !== (i == 0)) begin
        n_err++; $display("FAIL bp_beat[%0d]: got %h/%b expected %h/%b", i, got_d[i], got_nm[i], exp_beat(1'b1, i), (i == 0));
      end
    end
    for (int a = 0; a < 8; a++) begin
      res_rd_addr = 3'(7 - a);
      @(posedge clk); @(negedge clk);
      n_vec++; if (res_rd_data !== rm[7 - a]) begin n_err++; $display("FAIL bp_readback[%0d]: got %h expected %h", 7 - a, res_rd_data, rm[7 - a]); end
      @(posedge clk); #1;
    end
  endtask

  // X-only transfers with host writes and start pulses hammered during busy
  task automatic test_x_only_ignored_writes();
    for (int it = 0; it < 2; it++) begin
      for (int k = 0; k < 8; k++) res_q[k] = OUT_W'($urandom);
      run_transfer(1'b0, 1, 1'b1, 1'b1);
      n_vec++; if (timed_out) begin n_err++; $display("FAIL xonly_timeout: got no done expected done"); end
      n_vec++; if (got_d.size() != 8) begin n_err++; $display("FAIL xonly_beat_count: got %0d expected 8", got_d.size()); end
      for (int i = 0; i < got_d.size() && i < 8; i++) begin
        n_vec++;
        if (got_d[i] !== exp_beat(1'b0, i) || got_nm[i] !== 1'b0) begin
          n_err++; $display("FAIL xonly_beat[%0d]: got %h/%b expected %h/0", i, got_d[i], got_nm[i], exp_beat(1'b0, i));
        end
      end
    end
    // W must be untouched by the writes above
    for (int k = 0; k < 8; k++) res_q[k] = OUT_W'($urandom);
    run_transfer(1'b1, 1, 1'b0, 1'b1);
    n_vec++; if (got_d.size() != 72) begin n_err++; $display("FAIL persist_beat_count: got %0d expected 72", got_d.size()); end
    for (int i = 0; i < got_d.size() && i < 72; i++) begin
      n_vec++;
      if (got_d[i] !== exp_beat(1'b1, i) || got_nm[i] !== (i == 0)) begin
        n_err++; $display("FAIL persist_beat[%0d]: got %h/%b expected %h/%b", i, got_d[i], got_nm[i], exp_beat(1'b1, i), (i == 0));
      end
    end
  endtask

  task automatic test_mid_reset();
    int beats;
    beats = 0;
    @(posedge clk); #1;
    start = 1'b1; send_w = 1'b1; bus.mvm_in_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; send_w = 1'b0;
    for (int cyc = 0; cyc < 400 && beats < 20; cyc++) begin
      @(negedge clk);
      if (bus.mvm_in_valid && bus.mvm_in_ready) beats++;
      @(posedge clk); #1;
    end
    n_vec++; if (beats < 20) begin n_err++; $display("FAIL midrst_reach_beat20: got %0d beats expected 20", beats); end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    n_vec++;
    if (bus.mvm_in_valid !== 1'b0 || bus.mvm_new_matrix !== 1'b0 || bus.mvm_out_ready !== 1'b0 ||
        bus.mvm_in_data !== '0 || busy !== 1'b0 || done !== 1'b0 || res_rd_data !== '0) begin
      n_err++; $display("FAIL midrst_outputs: got v%b nm%b r%b d%h b%b dn%b rd%h expected all 0",
        bus.mvm_in_valid, bus.mvm_new_matrix, bus.mvm_out_ready, bus.mvm_in_data, busy, done, res_rd_data);
    end
    @(posedge clk); #1;
    rst = 1'b0; bus.mvm_in_ready = 1'b0;
    for (int k = 0; k < 8; k++) res_q[k] = OUT_W'($urandom);
    run_transfer(1'b1, 1, 1'b0, 1'b1);
    n_vec++; if (got_d.size() != 72) begin n_err++; $display("FAIL midrst_beat_count: got %0d expected 72", got_d.size()); end
    for (int i = 0; i < got_d.size() && i < 72; i++) begin
      n_vec++;
      if (got_d[i] !== exp_beat(1'b1, i) || got_nm[i] !== (i == 0)) begin
        n_err++; $display("FAIL midrst_beat[%0d]: got %h/%b expected %h/%b", i, got_d[i], got_nm[i], exp_beat(1'b1, i), (i == 0));
      end
    end
  endtask

  task automatic test_back_to_back();
    bit sw;
    for (int it = 0; it < 4; it++) begin
      if (it % 2 == 0) begin
        for (int i = 0; i < 64; i++) wm[i] = DATA_W'($urandom);
        for (int j = 0; j < 8; j++) xm[j] = DATA_W'($urandom);
        load_mem();
      end
      for (int k = 0; k < 8; k++) res_q[k] = OUT_W'($urandom);
      sw = 1'($urandom_range(0, 1));
      run_transfer(sw, 1, 1'b1, 1'b1);
      n_vec++; if (timed_out || stab_err != 0) begin n_err++; $display("FAIL b2b_run[%0d]: got timeout %b stab %0d expected 0 0", it, timed_out, stab_err); end
      n_vec++; if (got_d.size() != (sw ? 72 : 8)) begin n_err++; $display("FAIL b2b_beat_count[%0d]: got %0d expected %0d", it, got_d.size(), sw ? 72 : 8); end
      for (int i = 0; i < got_d.size() && i < (sw ? 72 : 8); i++) begin
        n_vec++;
        if (got_d[i] !== exp_beat(sw, i) || got_nm[i] !== (sw && i == 0)) begin
          n_err++; $display("FAIL b2b_beat[%0d][%0d]: got %h/%b expected %h/%b", it, i, got_d[i], got_nm[i], exp_beat(sw, i), (sw && i == 0));
        end
      end
      for (int a = 0; a < 8; a++) begin
        res_rd_addr = 3'(a);
        @(posedge clk); @(negedge clk);
        n_vec++; if (res_rd_data !== rm[a]) begin n_err++; $display("FAIL b2b_readback[%0d][%0d]: got %h expected %h", it, a, res_rd_data, rm[a]); end
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    bus.mvm_in_ready  = 1'b0;
    bus.mvm_out_valid = 1'b0;
    bus.mvm_out_data  = '0;
    test_reset();
    test_basic_stream();
    test_backpressure();
    test_x_only_ignored_writes();
    test_mid_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
